// File: rtl/multicycle_control_if.sv
// Control-unit bundle: memory handshake, ALU function fields, datapath
// selects/strobes, trap flags and debug state.
interface multicycle_control_if;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        zero;
   logic        mem_req;
   logic        mem_we;
   logic        mem_addr_sel;
   logic [6:0]  alu_opcode;
   logic [2:0]  alu_funct3;
   logic [6:0]  alu_funct7;
   logic        src_a_sel;
   logic        src_b_sel;
   logic [2:0]  imm_sel;
   logic        pc_we;
   logic [1:0]  pc_src;
   logic        oldpc_we;
   logic        reg_we;
   logic [1:0]  wb_sel;
   logic        illegal;
   logic        bus_err;
   logic [31:0] instret;
   logic [3:0]  state;

   // The control unit drives everything except memory data/ready and Zero.
   modport master (
      input  mem_rdata, mem_ready, zero,
      output mem_req, mem_we, mem_addr_sel, alu_opcode, alu_funct3, alu_funct7,
             src_a_sel, src_b_sel, imm_sel, pc_we, pc_src, oldpc_we, reg_we,
             wb_sel, illegal, bus_err, instret, state
   );

   // Memory/datapath side.
   modport slave (
      output mem_rdata, mem_ready, zero,
      input  mem_req, mem_we, mem_addr_sel, alu_opcode, alu_funct3, alu_funct7,
             src_a_sel, src_b_sel, imm_sel, pc_we, pc_src, oldpc_we, reg_we,
             wb_sel, illegal, bus_err, instret, state
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I-subset control unit. Fetches into an instruction
// register, sequences each instruction class through its states and
// drives the ALU fields, datapath selects, strobes and memory requests.
module multicycle_control #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] IR_RESET = 32'h0000_0013
) (
   input logic              clk,
   input logic              rst_n,
   multicycle_control_if.master bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC     = 4'd2,
      MEM_ADDR = 4'd3,
      MEM_RD   = 4'd4,
      MEM_WR   = 4'd5,
      WB_ALU   = 4'd6,
      WB_MEM   = 4'd7,
      BRANCH   = 4'd8,
      JUMP     = 4'd9,
      TRAP     = 4'd10
   } state_t;

   localparam logic [2:0]  IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;
   localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [31:0] ir;
   logic [31:0] instret_q;
   logic        illegal_q, bus_err_q;
   logic [15:0] wait_cnt;

   logic        mem_req, mem_we, mem_addr_sel, src_a_sel, src_b_sel;
   logic        pc_we, oldpc_we, reg_we;
   logic [2:0]  imm_sel;
   logic [1:0]  pc_src, wb_sel;
   logic        ir_load, retire, set_illegal, set_bus_err;

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic        is_r, is_i, is_lui, is_lw, is_sw, is_br, is_jal, taken, wait_last;
   logic        unused_ir;

   assign opc       = ir[6:0];
   assign f3        = ir[14:12];
   assign unused_ir = ^{ir[24:15], ir[11:7]};

   assign is_r   = (opc == 7'b0110011) &&
                   (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b010 || f3 == 3'b101);
   assign is_i   = (opc == 7'b0010011) &&
                   (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b010);
   assign is_lui = (opc == 7'b0110111);
   assign is_lw  = (opc == 7'b0000011) && (f3 == 3'b010);
   assign is_sw  = (opc == 7'b0100011) && (f3 == 3'b010);
   assign is_br  = (opc == 7'b1100011) && (f3 == 3'b000 || f3 == 3'b001);
   assign is_jal = (opc == 7'b1101111);
   assign taken  = ((f3 == 3'b000) && bus.zero) || ((f3 == 3'b001) && !bus.zero);

   // Final stalled cycle before the bus-error trap; mem_ready still wins here.
   assign wait_last = (wait_cnt == LAST_WAIT);

   // Next state and all strobes/selects, decoded from state and inputs.
   always_comb begin
      state_d      = state_q;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      src_a_sel    = 1'b0;
      src_b_sel    = 1'b0;
      imm_sel      = IMM_I;
      pc_we        = 1'b0;
      pc_src       = 2'd0;
      oldpc_we     = 1'b0;
      reg_we       = 1'b0;
      wb_sel       = 2'd0;
      ir_load      = 1'b0;
      retire       = 1'b0;
      set_illegal  = 1'b0;
      set_bus_err  = 1'b0;
      case (state_q)
         FETCH: begin
            mem_req = 1'b1;
            if (bus.mem_ready) begin
               ir_load  = 1'b1;
               pc_we    = 1'b1;
               oldpc_we = 1'b1;
               state_d  = DECODE;
            end else if (wait_last) begin
               set_bus_err = 1'b1;
               state_d     = TRAP;
            end
         end
         DECODE: begin
            if (is_r || is_i || is_lui) state_d = EXEC;
            else if (is_lw || is_sw)    state_d = MEM_ADDR;
            else if (is_br)             state_d = BRANCH;
            else if (is_jal)            state_d = JUMP;
            else begin
               set_illegal = 1'b1;
               state_d     = TRAP;
            end
         end
         EXEC, WB_ALU: begin
            // LUI adds its U-immediate to a zero A operand.
            src_a_sel = is_lui;
            src_b_sel = !is_r;
            imm_sel   = is_lui ? IMM_U : IMM_I;
            if (state_q == EXEC) begin
               state_d = WB_ALU;
            end else begin
               reg_we  = 1'b1;
               retire  = 1'b1;
               state_d = FETCH;
            end
         end
         MEM_ADDR: begin
            src_b_sel = 1'b1;
            imm_sel   = is_sw ? IMM_S : IMM_I;
            state_d   = is_sw ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            src_b_sel    = 1'b1;
            if (bus.mem_ready) state_d = WB_MEM;
            else if (wait_last) begin
               set_bus_err = 1'b1;
               state_d     = TRAP;
            end
         end
         WB_MEM: begin
            reg_we  = 1'b1;
            wb_sel  = 2'd1;
            retire  = 1'b1;
            state_d = FETCH;
         end
         MEM_WR: begin
            mem_req      = 1'b1;
            mem_we       = 1'b1;
            mem_addr_sel = 1'b1;
            src_b_sel    = 1'b1;
            imm_sel      = IMM_S;
            if (bus.mem_ready) begin
               retire  = 1'b1;
               state_d = FETCH;
            end else if (wait_last) begin
               set_bus_err = 1'b1;
               state_d     = TRAP;
            end
         end
         BRANCH: begin
            imm_sel = IMM_B;
            pc_src  = 2'd1;
            pc_we   = taken;
            retire  = 1'b1;
            state_d = FETCH;
         end
         JUMP: begin
            reg_we  = 1'b1;
            wb_sel  = 2'd2;
            pc_we   = 1'b1;
            pc_src  = 2'd2;
            imm_sel = IMM_J;
            retire  = 1'b1;
            state_d = FETCH;
         end
         default: state_d = state_q;
      endcase
      // While reset is held nothing may leave the unit asserted.
      if (!rst_n) begin
         mem_req      = 1'b0;
         mem_we       = 1'b0;
         mem_addr_sel = 1'b0;
         src_a_sel    = 1'b0;
         src_b_sel    = 1'b0;
         imm_sel      = IMM_I;
         pc_we        = 1'b0;
         pc_src       = 2'd0;
         oldpc_we     = 1'b0;
         reg_we       = 1'b0;
         wb_sel       = 2'd0;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;
   end

   // Instruction register, loaded on a completed fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ir <= IR_RESET;
      else if (ir_load) ir <= bus.mem_rdata;
   end

   // Retired-instruction counter (wraps naturally).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      instret_q <= 32'd0;
      else if (retire) instret_q <= instret_q + 32'd1;
   end

   // Sticky trap flags, released only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         if (set_illegal) illegal_q <= 1'b1;
         if (set_bus_err) bus_err_q <= 1'b1;
      end
   end

   // Stall counter: counts unanswered request cycles, clears otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                       wait_cnt <= 16'd0;
      else if (mem_req && !bus.mem_ready && !wait_last) wait_cnt <= wait_cnt + 16'd1;
      else                                              wait_cnt <= 16'd0;
   end

   assign bus.mem_req      = mem_req;
   assign bus.mem_we       = mem_we;
   assign bus.mem_addr_sel = mem_addr_sel;
   assign bus.alu_opcode   = ir[6:0];
   assign bus.alu_funct3   = ir[14:12];
   assign bus.alu_funct7   = ir[31:25];
   assign bus.src_a_sel    = src_a_sel;
   assign bus.src_b_sel    = src_b_sel;
   assign bus.imm_sel      = imm_sel;
   assign bus.pc_we        = pc_we;
   assign bus.pc_src       = pc_src;
   assign bus.oldpc_we     = oldpc_we;
   assign bus.reg_we       = reg_we;
   assign bus.wb_sel       = wb_sel;
   assign bus.illegal      = illegal_q;
   assign bus.bus_err      = bus_err_q;
   assign bus.instret      = instret_q;
   assign bus.state        = state_q;

endmodule
